// File: rtl/regfile_wb.sv
// regfile_wb: writeback stage and architectural register file.
//
// Picks the writeback value from the MEM/WB register (branch-and-link,
// load data or ALU result) and commits it to an NREGS x DW register file
// on the rising clock edge. Index NREGS-1 is the zero register: writes to
// it are dropped and reads of it return zero. Two combinational read ports
// serve decode. A one-cycle registered record of the last committed write
// (wb_valid_q / wb_rd_q / wb_data_q) is exported for the forwarding unit.
//
// Optional feature, macro REGFILE_WB_BYPASS_EN:
//   defined   - write-through bypass: a read port addressing the register
//               being written this cycle returns the write data before the
//               edge, so decode needs no WB-to-ID forwarding path.
//   undefined - reads return the pre-edge array contents only.
//
// Handshake: there is none. The WB inputs are qualified by RegWrite_wb /
// BLsignal_wb alone and are consumed on every rising edge; there is no
// back-pressure.

module regfile_wb #(
    parameter int NREGS    = 32,
    parameter int DW       = 64,
    parameter int LINK_REG = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RegWrite_wb,
    input  logic          MemtoReg_wb,
    input  logic          BLsignal_wb,
    input  logic [4:0]    Rd_wb,
    input  logic [DW-1:0] dm_read_data_wb,
    input  logic [DW-1:0] alu_result_wb,
    input  logic [DW-1:0] BLT_wb,
    input  logic [4:0]    Rn,
    input  logic [4:0]    Rm,
    output logic [DW-1:0] Da,
    output logic [DW-1:0] Db,
    output logic          wb_valid_q,
    output logic [4:0]    wb_rd_q,
    output logic [DW-1:0] wb_data_q
);

    localparam logic [4:0] ZR_IDX   = 5'(NREGS - 1);
    localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

    // Architectural state.
    logic [DW-1:0] regs_q [NREGS];

    // Selected write for this cycle.
    logic          wr_sel;
    logic [4:0]    wdest;
    logic [DW-1:0] wdata;
    logic          wr_en;

    // Next-state of the forwarding record.
    logic          wb_valid_d;
    logic [4:0]    wb_rd_d;
    logic [DW-1:0] wb_data_d;

    // Write select: branch-and-link overrides a normal writeback and is
    // taken even when RegWrite_wb is low; Rd_wb is ignored in that case.
    always_comb begin
        wr_sel = 1'b0;
        wdest  = '0;
        wdata  = '0;
        if (BLsignal_wb) begin
            wr_sel = 1'b1;
            wdest  = LINK_IDX;
            wdata  = BLT_wb;
        end else if (RegWrite_wb) begin
            wr_sel = 1'b1;
            wdest  = Rd_wb;
            wdata  = MemtoReg_wb ? dm_read_data_wb : alu_result_wb;
        end
    end

    // A selected write only commits when it does not target the zero register.
    assign wr_en = wr_sel && (wdest != ZR_IDX);

    // Forwarding record: valid tracks every edge, index/data hold when idle.
    always_comb begin
        wb_valid_d = wr_en;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (wr_en) begin
            wb_rd_d   = wdest;
            wb_data_d = wdata;
        end
    end

    // Register array: cleared by reset, one write port committing on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wdest] <= wdata;
        end
    end

    // Forwarding record registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Read port A: zero register reads zero; reset forces zero so a bypassed
    // value cannot leak out while the array is held clear.
    always_comb begin
        Da = '0;
        if (!reset && (Rn != ZR_IDX)) begin
`ifdef REGFILE_WB_BYPASS_EN
            if (wr_en && (wdest == Rn)) begin
                Da = wdata;
            end else begin
                Da = regs_q[Rn];
            end
`else
            Da = regs_q[Rn];
`endif
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        Db = '0;
        if (!reset && (Rm != ZR_IDX)) begin
`ifdef REGFILE_WB_BYPASS_EN
            if (wr_en && (wdest == Rm)) begin
                Db = wdata;
            end else begin
                Db = regs_q[Rm];
            end
`else
            Db = regs_q[Rm];
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed and randomized bench for regfile_wb against a
// behavioural register-file model held in plain arrays.

module tb_regfile_wb;

    logic        clk;
    logic        reset;
    logic        RegWrite_wb;
    logic        MemtoReg_wb;
    logic        BLsignal_wb;
    logic [4:0]  Rd_wb;
    logic [63:0] dm_read_data_wb;
    logic [63:0] alu_result_wb;
    logic [63:0] BLT_wb;
    logic [4:0]  Rn;
    logic [4:0]  Rm;
    logic [63:0] Da;
    logic [63:0] Db;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [63:0] wb_data_q;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural contents and expected forwarding record.
    logic [63:0] model [32];
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic [63:0] exp_data;

    regfile_wb dut (
        .clk             (clk),
        .reset           (reset),
        .RegWrite_wb     (RegWrite_wb),
        .MemtoReg_wb     (MemtoReg_wb),
        .BLsignal_wb     (BLsignal_wb),
        .Rd_wb           (Rd_wb),
        .dm_read_data_wb (dm_read_data_wb),
        .alu_result_wb   (alu_result_wb),
        .BLT_wb          (BLT_wb),
        .Rn              (Rn),
        .Rm              (Rm),
        .Da              (Da),
        .Db              (Db),
        .wb_valid_q      (wb_valid_q),
        .wb_rd_q         (wb_rd_q),
        .wb_data_q       (wb_data_q)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What the current WB inputs ask to be written (architecturally effective).
    task automatic cur_write(output bit we, output logic [4:0] d, output logic [63:0] v);
        we = 1'b0;
        d  = '0;
        v  = '0;
        if (BLsignal_wb) begin
            d = 5'd30; v = BLT_wb; we = 1'b1;
        end else if (RegWrite_wb) begin
            d = Rd_wb; v = MemtoReg_wb ? dm_read_data_wb : alu_result_wb; we = 1'b1;
        end
        if (d == 5'd31) we = 1'b0;
    endtask

    // Expected value of a read port at this moment.
    task automatic exp_read(input logic [4:0] a, output logic [63:0] r);
        bit          we;
        logic [4:0]  d;
        logic [63:0] v;
        cur_write(we, d, v);
        if (reset || a == 5'd31) r = '0;
`ifdef REGFILE_WB_BYPASS_EN
        else if (we && d == a) r = v;
`endif
        else r = model[a];
    endtask

    task automatic check_reads(input string tag);
        logic [63:0] ea, eb;
        exp_read(Rn, ea);
        exp_read(Rm, eb);
        chk({tag, "_Da"}, Da, ea);
        chk({tag, "_Db"}, Db, eb);
    endtask

    task automatic check_record(input string tag);
        chk({tag, "_valid"}, {63'd0, wb_valid_q}, {63'd0, exp_valid});
        chk({tag, "_rd"},    {59'd0, wb_rd_q},    {59'd0, exp_rd});
        chk({tag, "_data"},  wb_data_q,           exp_data);
    endtask

    // One clock edge; the model commits whatever the inputs held at the edge.
    task automatic tick();
        bit          we;
        logic [4:0]  d;
        logic [63:0] v;
        cur_write(we, d, v);
        @(posedge clk);
        if (!reset) begin
            exp_valid = we;
            if (we) begin
                model[d] = v;
                exp_rd   = d;
                exp_data = v;
            end
        end
        #1;
    endtask

    task automatic drive(input bit bl, input bit rw, input bit m2r, input logic [4:0] rd,
                         input logic [63:0] dm, input logic [63:0] alu, input logic [63:0] blt);
        BLsignal_wb     = bl;
        RegWrite_wb     = rw;
        MemtoReg_wb     = m2r;
        Rd_wb           = rd;
        dm_read_data_wb = dm;
        alu_result_wb   = alu;
        BLT_wb          = blt;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_valid = 1'b0;
        exp_rd    = '0;
        exp_data  = '0;
    endtask

    initial begin
        logic [63:0] e;
        reset = 1'b1;
        Rn = '0;
        Rm = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // Reset: every address reads zero on both ports, record cleared.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            Rn = 5'(i);
            Rm = 5'(31 - i);
            #1;
            chk("rst_Da", Da, 64'd0);
            chk("rst_Db", Db, 64'd0);
        end
        check_record("rst");
        reset = 1'b0;
        tick();

        // ALU writeback to X5.
        drive(0, 1, 0, 5'd5, 64'hDEAD, 64'h1234, 64'h0);
        tick();
        Rn = 5'd5;
        #1;
        chk("alu_Da", Da, 64'h1234);
        chk("alu_valid", {63'd0, wb_valid_q}, 64'd1);
        chk("alu_rd", {59'd0, wb_rd_q}, 64'd5);
        chk("alu_data", wb_data_q, 64'h1234);

        // Load writeback to X6.
        drive(0, 1, 1, 5'd6, 64'hBEEF, 64'h7777, 64'h0);
        tick();
        Rm = 5'd6;
        #1;
        chk("load_Db", Db, 64'hBEEF);
        check_record("load");

        // Write to XZR is discarded; record holds index 6.
        drive(0, 1, 0, 5'd31, 64'h0, 64'hFFFF, 64'h0);
        tick();
        Rn = 5'd31;
        #1;
        chk("xzr_Da", Da, 64'd0);
        chk("xzr_valid", {63'd0, wb_valid_q}, 64'd0);
        chk("xzr_rd_hold", {59'd0, wb_rd_q}, 64'd6);

        // Branch-and-link with RegWrite low: X30 written, X3 untouched.
        drive(1, 0, 0, 5'd3, 64'h0, 64'h0, 64'h400);
        tick();
        Rn = 5'd30;
        Rm = 5'd3;
        #1;
        chk("bl_x30", Da, 64'h400);
        chk("bl_x3", Db, 64'd0);
        chk("bl_rd", {59'd0, wb_rd_q}, 64'd30);
        check_record("bl");

        // Branch-and-link wins over RegWrite to another register.
        drive(1, 1, 0, 5'd4, 64'h0, 64'h999, 64'h808);
        tick();
        Rn = 5'd30;
        Rm = 5'd4;
        #1;
        chk("blrw_x30", Da, 64'h808);
        chk("blrw_x4", Db, 64'd0);

        // Same-cycle read of a register being written.
        drive(0, 1, 0, 5'd7, 64'h0, 64'h11, 64'h0);
        tick();
        drive(0, 1, 0, 5'd7, 64'h0, 64'hAA, 64'h0);
        Rn = 5'd7;
        Rm = 5'd7;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        chk("byp_pre", Da, 64'hAA);
`else
        chk("byp_pre", Da, 64'h11);
`endif
        chk("byp_same", Db, Da);
        tick();
        chk("byp_post", Da, 64'hAA);

        // Reset in the middle of a pending write loses that write.
        drive(0, 1, 0, 5'd9, 64'h0, 64'h55, 64'h0);
        tick();
        Rn = 5'd9;
        #1;
        chk("pre_rst_x9", Da, 64'h55);
        drive(0, 1, 0, 5'd9, 64'h0, 64'h66, 64'h0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_now_x9", Da, 64'd0);
        check_record("rst_now");
        @(posedge clk);
        #1;
        chk("rst_edge_x9", Da, 64'd0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_rel_x9", Da, 64'd0);
        check_record("rst_rel");
        tick();
        chk("rst_after_x9", Da, 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  rd, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            Rn = 5'($urandom_range(0, 31));
            Rm = ($urandom_range(0, 4) == 0) ? Rn : 5'($urandom_range(0, 31));
            #1;
            check_reads("rnd_pre");
            tick();
            check_reads("rnd_post");
            check_record("rnd");
        end

        // Final sweep of the whole file with writes idle.
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            Rn = 5'(i);
            Rm = 5'(i);
            #1;
            exp_read(Rn, e);
            chk("sweep", Da, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
